// File: rtl/opp_word_unpack.sv
// opp_word_unpack
// Filters the raw opponent word coming out of the receive-domain buffer.
// A word is only looked at once it has stayed bit-identical for
// STABLE_CYCLES edges, so torn or half-updated words are never used. Each
// stable word is evaluated exactly once. Its fields are range-checked, and a
// small FSM tracks whether the link is healthy.
//
// Ports
//   clk_in        in   1   pixel clock (65 MHz)
//   rst_in        in   1   synchronous, active-high reset
//   word_in       in  45   raw word: [44] valid, [43:33] x, [31:21] y,
//                          [19:11] dir, [7:5] game, [3] reset; other bits ignored
//   opp_x         out 11   last accepted x
//   opp_y         out 11   last accepted y
//   opp_dir       out  9   last accepted direction (degrees)
//   opp_game      out  3   last accepted game status
//   opp_upd       out  1   one-cycle strobe when the fields are rewritten
//   opp_rst_pulse out  1   one-cycle strobe on an accepted reset-bit 0->1
//   link_up       out  1   high while the link FSM is LINKED
//   reject_cnt    out  8   saturating count of rejected evaluations
module opp_word_unpack #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned GOOD_TO_LINK  = 3,
  parameter int unsigned BAD_TO_DROP   = 8,
  parameter int unsigned X_MAX         = 1023,
  parameter int unsigned Y_MAX         = 767,
  parameter int unsigned DIR_MAX       = 359,
  parameter int unsigned GAME_MAX      = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [44:0] word_in,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [2:0]  opp_game,
  output logic        opp_upd,
  output logic        opp_rst_pulse,
  output logic        link_up,
  output logic [7:0]  reject_cnt
);

  localparam int unsigned GW = $clog2(GOOD_TO_LINK + 1);
  localparam int unsigned BW = $clog2(BAD_TO_DROP + 1);

  localparam logic [3:0]    STAB_C   = 4'(STABLE_CYCLES);
  localparam logic [3:0]    STAB_M1  = 4'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GOOD_C   = GW'(GOOD_TO_LINK);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);
  localparam logic [BW-1:0] BAD_C    = BW'(BAD_TO_DROP);
  localparam logic [BW-1:0] BAD_ONE  = BW'(1);
  localparam logic [10:0]   X_MAX_C  = 11'(X_MAX);
  localparam logic [10:0]   Y_MAX_C  = 11'(Y_MAX);
  localparam logic [8:0]    DIR_MAX_C  = 9'(DIR_MAX);
  localparam logic [2:0]    GAME_MAX_C = 3'(GAME_MAX);

  typedef enum logic [1:0] {
    NO_LINK = 2'd0,
    SYNCING = 2'd1,
    LINKED  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [44:0]   prev_word_q, prev_word_d;
  logic [3:0]    stab_cnt_q, stab_cnt_d;
  logic [GW-1:0] good_run_q, good_run_d;
  logic [BW-1:0] bad_run_q, bad_run_d;
  logic          last_rst_q, last_rst_d;
  logic [10:0]   opp_x_q, opp_x_d;
  logic [10:0]   opp_y_q, opp_y_d;
  logic [8:0]    opp_dir_q, opp_dir_d;
  logic [2:0]    opp_game_q, opp_game_d;
  logic          opp_upd_q, opp_upd_d;
  logic          opp_rst_pulse_q, opp_rst_pulse_d;
  logic          link_up_q, link_up_d;
  logic [7:0]    reject_cnt_q, reject_cnt_d;

  // Field views of the incoming word; only consumed on an evaluation edge,
  // where word_in equals prev_word_q.
  logic          f_valid_s, f_rst_s, accept_s, eval_s;
  logic [10:0]   f_x_s, f_y_s;
  logic [8:0]    f_dir_s;
  logic [2:0]    f_game_s;

  assign f_valid_s = word_in[44];
  assign f_x_s     = word_in[43:33];
  assign f_y_s     = word_in[31:21];
  assign f_dir_s   = word_in[19:11];
  assign f_game_s  = word_in[7:5];
  assign f_rst_s   = word_in[3];

  assign accept_s = f_valid_s && (f_x_s <= X_MAX_C) && (f_y_s <= Y_MAX_C) &&
                    (f_dir_s <= DIR_MAX_C) && (f_game_s <= GAME_MAX_C);

  // Stability filter, evaluation outcome and link FSM next-state.
  always_comb begin
    prev_word_d     = prev_word_q;
    stab_cnt_d      = stab_cnt_q;
    state_d         = state_q;
    good_run_d      = good_run_q;
    bad_run_d       = bad_run_q;
    last_rst_d      = last_rst_q;
    opp_x_d         = opp_x_q;
    opp_y_d         = opp_y_q;
    opp_dir_d       = opp_dir_q;
    opp_game_d      = opp_game_q;
    opp_upd_d       = 1'b0;
    opp_rst_pulse_d = 1'b0;
    reject_cnt_d    = reject_cnt_q;
    eval_s          = 1'b0;

    // Any change (even back to an older value) restarts the count; the count
    // parks at STABLE_CYCLES so a held word is evaluated only once.
    if (word_in != prev_word_q) begin
      prev_word_d = word_in;
      stab_cnt_d  = 4'd0;
    end else if (stab_cnt_q < STAB_C) begin
      stab_cnt_d = stab_cnt_q + 4'd1;
      eval_s     = (stab_cnt_q == STAB_M1);
    end else begin
      stab_cnt_d = stab_cnt_q;
    end

    if (eval_s) begin
      if (accept_s) begin
        opp_x_d         = f_x_s;
        opp_y_d         = f_y_s;
        opp_dir_d       = f_dir_s;
        opp_game_d      = f_game_s;
        opp_upd_d       = 1'b1;
        opp_rst_pulse_d = f_rst_s && !last_rst_q;
        last_rst_d      = f_rst_s;
        good_run_d      = (good_run_q == GOOD_C) ? good_run_q : good_run_q + GOOD_ONE;
        bad_run_d       = '0;
      end else begin
        reject_cnt_d = (reject_cnt_q == 8'd255) ? reject_cnt_q : reject_cnt_q + 8'd1;
        bad_run_d    = (bad_run_q == BAD_C) ? bad_run_q : bad_run_q + BAD_ONE;
        good_run_d   = '0;
      end

      case (state_q)
        NO_LINK: begin
          if (accept_s) begin
            state_d = SYNCING;
          end else begin
            state_d = NO_LINK;
          end
        end
        SYNCING: begin
          if (!accept_s) begin
            state_d = NO_LINK;
          end else if (good_run_d == GOOD_C) begin
            state_d = LINKED;
          end else begin
            state_d = SYNCING;
          end
        end
        LINKED: begin
          // Clearing the stored reset bit lets a still-held reset bit pulse
          // again once the link comes back.
          if (!accept_s && (bad_run_d == BAD_C)) begin
            state_d    = NO_LINK;
            last_rst_d = 1'b0;
          end else begin
            state_d = LINKED;
          end
        end
        default: begin
          state_d = NO_LINK;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    link_up_d = (state_d == LINKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= NO_LINK;
      prev_word_q     <= '0;
      stab_cnt_q      <= 4'd0;
      good_run_q      <= '0;
      bad_run_q       <= '0;
      last_rst_q      <= 1'b0;
      opp_x_q         <= 11'd0;
      opp_y_q         <= 11'd0;
      opp_dir_q       <= 9'd0;
      opp_game_q      <= 3'd0;
      opp_upd_q       <= 1'b0;
      opp_rst_pulse_q <= 1'b0;
      link_up_q       <= 1'b0;
      reject_cnt_q    <= 8'd0;
    end else begin
      state_q         <= state_d;
      prev_word_q     <= prev_word_d;
      stab_cnt_q      <= stab_cnt_d;
      good_run_q      <= good_run_d;
      bad_run_q       <= bad_run_d;
      last_rst_q      <= last_rst_d;
      opp_x_q         <= opp_x_d;
      opp_y_q         <= opp_y_d;
      opp_dir_q       <= opp_dir_d;
      opp_game_q      <= opp_game_d;
      opp_upd_q       <= opp_upd_d;
      opp_rst_pulse_q <= opp_rst_pulse_d;
      link_up_q       <= link_up_d;
      reject_cnt_q    <= reject_cnt_d;
    end
  end

  assign opp_x         = opp_x_q;
  assign opp_y         = opp_y_q;
  assign opp_dir       = opp_dir_q;
  assign opp_game      = opp_game_q;
  assign opp_upd       = opp_upd_q;
  assign opp_rst_pulse = opp_rst_pulse_q;
  assign link_up       = link_up_q;
  assign reject_cnt    = reject_cnt_q;

endmodule

// File: tb/tb_opp_word_unpack.sv
// Self-checking bench for opp_word_unpack. Each held word that lives long
// enough to be evaluated pushes an expected record (cycle, strobes, fields,
// link, reject count) into a scoreboard queue; a negedge monitor pops and
// compares it on that cycle and expects both strobes low on every other cycle.
module tb_opp_word_unpack;

  localparam int STABLE = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [44:0] word_in;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_upd, opp_rst_pulse, link_up;
  logic [7:0]  reject_cnt;

  opp_word_unpack dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .word_in       (word_in),
    .opp_x         (opp_x),
    .opp_y         (opp_y),
    .opp_dir       (opp_dir),
    .opp_game      (opp_game),
    .opp_upd       (opp_upd),
    .opp_rst_pulse (opp_rst_pulse),
    .link_up       (link_up),
    .reject_cnt    (reject_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          cyc;
    logic        upd;
    logic        rp;
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  game;
    logic        link;
    logic [7:0]  rc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state (link: 0 NO_LINK, 1 SYNCING, 2 LINKED)
  logic [10:0] m_x, m_y;
  logic [8:0]  m_dir;
  logic [2:0]  m_game;
  logic        m_last;
  int          m_st, m_good, m_bad, m_rc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [44:0] mk(input logic v, input int x, input int y,
                                     input int d, input int g, input logic r,
                                     input int junk);
    logic [44:0] w;
    logic [5:0]  j;
    w = '0;
    j = junk[5:0];
    w[44]    = v;
    w[43:33] = x[10:0];
    w[31:21] = y[10:0];
    w[19:11] = d[8:0];
    w[7:5]   = g[2:0];
    w[3]     = r;
    w[2:0]   = j[2:0];
    w[10:8]  = j[5:3];
    return w;
  endfunction

  task automatic model_reset();
    m_x = '0; m_y = '0; m_dir = '0; m_game = '0; m_last = 1'b0;
    m_st = 0; m_good = 0; m_bad = 0; m_rc = 0;
  endtask

  task automatic model_eval(input logic [44:0] w, input int tcyc);
    exp_t e;
    logic acc, rp;
    acc = w[44] && (w[43:33] <= 11'd1023) && (w[31:21] <= 11'd767) &&
          (w[19:11] <= 9'd359) && (w[7:5] <= 3'd4);
    rp = 1'b0;
    if (acc) begin
      m_x = w[43:33]; m_y = w[31:21]; m_dir = w[19:11]; m_game = w[7:5];
      rp = w[3] && !m_last;
      m_last = w[3];
      m_good = (m_good < 3) ? m_good + 1 : 3;
      m_bad = 0;
    end else begin
      m_rc = (m_rc < 255) ? m_rc + 1 : 255;
      m_bad = (m_bad < 8) ? m_bad + 1 : 8;
      m_good = 0;
    end
    if (m_st == 0) begin
      if (acc) m_st = 1;
    end else if (m_st == 1) begin
      if (!acc) m_st = 0;
      else if (m_good == 3) m_st = 2;
    end else begin
      if (!acc && m_bad == 8) begin
        m_st = 0;
        m_last = 1'b0;
      end
    end
    e.cyc = tcyc; e.upd = acc; e.rp = rp;
    e.x = m_x; e.y = m_y; e.dir = m_dir; e.game = m_game;
    e.link = (m_st == 2); e.rc = m_rc[7:0];
    exp_q.push_back(e);
  endtask

  // Drive w for n edges; an evaluation happens iff it survives STABLE+1 edges.
  task automatic hold_word(input logic [44:0] w, input int n);
    word_in = w;
    if (n > STABLE) model_eval(w, cyc + STABLE + 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_x", opp_x, 0);
    chk("rst_y", opp_y, 0);
    chk("rst_dir", opp_dir, 0);
    chk("rst_game", opp_game, 0);
    chk("rst_upd", opp_upd, 0);
    chk("rst_pulse", opp_rst_pulse, 0);
    chk("rst_link", link_up, 0);
    chk("rst_rc", reject_cnt, 0);
    rst_in = 1'b0;
    model_reset();
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk_in) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      chk("upd", opp_upd, mon_e.upd);
      chk("rst_pulse", opp_rst_pulse, mon_e.rp);
      chk("x", opp_x, mon_e.x);
      chk("y", opp_y, mon_e.y);
      chk("dir", opp_dir, mon_e.dir);
      chk("game", opp_game, mon_e.game);
      chk("link_up", link_up, mon_e.link);
      chk("reject_cnt", reject_cnt, mon_e.rc);
    end else begin
      chk("upd_idle", opp_upd, 0);
      chk("pulse_idle", opp_rst_pulse, 0);
    end
  end

  initial begin
    logic [44:0] wa, wb;
    rst_in  = 1'b1;
    word_in = '0;
    model_reset();
    do_reset();

    // Basic accept: fields after 4 cycles, SYNCING, no link yet.
    hold_word(mk(1'b1, 100, 200, 90, 1, 1'b0, 0), 6);

    // Toggling words (differing only in ignored bit 32) never evaluate.
    wa = mk(1'b1, 5, 5, 5, 0, 1'b0, 0);
    wb = wa;
    wb[32] = 1'b1;
    for (int i = 0; i < 25; i++) hold_word((i % 2 == 0) ? wa : wb, 2);
    chk("toggle_rc", reject_cnt, 0);
    chk("toggle_x", opp_x, 100);

    // Reset with stab_cnt = 2, then the same word needs the full count.
    hold_word(mk(1'b1, 300, 400, 180, 2, 1'b0, 1), 3);
    do_reset();
    hold_word(mk(1'b1, 300, 400, 180, 2, 1'b0, 1), 6);

    // Boundary accepts and link-up on the third accept.
    hold_word(mk(1'b1, 1023, 767, 359, 4, 1'b0, 2), 6);
    hold_word(mk(1'b1, 0, 0, 0, 0, 1'b0, 3), 6);
    chk("linked", link_up, 1);

    // Just-out-of-range rejects: fields hold, link stays.
    hold_word(mk(1'b1, 1100, 10, 10, 1, 1'b0, 4), 6);
    hold_word(mk(1'b1, 10, 768, 10, 1, 1'b0, 5), 6);
    hold_word(mk(1'b1, 10, 10, 360, 1, 1'b0, 6), 6);
    hold_word(mk(1'b1, 10, 10, 10, 5, 1'b0, 7), 6);
    chk("still_linked", link_up, 1);

    // One accept clears the bad run, then 8 invalid words drop the link.
    hold_word(mk(1'b1, 50, 60, 70, 3, 1'b0, 8), 6);
    for (int i = 0; i < 8; i++) hold_word(mk(1'b0, 20 + i, 1, 1, 1, 1'b0, 9), 6);
    chk("dropped", link_up, 0);

    // Reset-bit pulse: 0 then 1 pulses, held 1 does not.
    hold_word(mk(1'b1, 1, 1, 1, 1, 1'b0, 10), 6);
    hold_word(mk(1'b1, 2, 2, 2, 1, 1'b1, 11), 6);
    hold_word(mk(1'b1, 3, 3, 3, 1, 1'b1, 12), 6);
    // Drop from LINKED, relink with reset=1 pulses again.
    for (int i = 0; i < 8; i++) hold_word(mk(1'b0, 40 + i, 1, 1, 1, 1'b1, 13), 6);
    hold_word(mk(1'b1, 4, 4, 4, 1, 1'b1, 14), 6);
    // A reject from SYNCING does not forget the stored reset bit.
    hold_word(mk(1'b0, 5, 5, 5, 1, 1'b1, 15), 6);
    hold_word(mk(1'b1, 6, 6, 6, 1, 1'b1, 16), 6);

    // Saturate the reject counter.
    for (int i = 0; i < 300; i++) hold_word(mk(1'b0, i, 0, 0, 0, 1'b0, 17), 6);
    chk("rc_sat", reject_cnt, 255);

    repeat (10) @(posedge clk_in);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
